// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int IDX_BITS_DEF = 8;

    // Widest word index a 32-bit byte address can carry; narrower indices are zero-extended.
    localparam int IDX_MAX = 30;

    typedef struct packed {
        logic [IDX_MAX-1:0] idx;
        logic [31:0]        data;
    } sb_entry_t;

    // Word index of a byte address, keeping only the low idxBits so that
    // addresses aliasing in memory also alias in the store buffer.
    function automatic logic [IDX_MAX-1:0] wordIdx(input logic [31:0] addr, input int idxBits);
        logic [IDX_MAX-1:0] mask;
        mask = '0;
        for (int b = 0; b < IDX_MAX; b++) begin
            if (b < idxBits) mask[b] = 1'b1;
        end
        return addr[31:2] & mask;
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order store buffer: circular FIFO with a youngest-match lookup for load forwarding.
module store_buffer_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [IDX_MAX-1:0] pushIdx,
    input  logic [31:0]        pushData,
    input  logic               pop,
    output logic [IDX_MAX-1:0] headIdx,
    output logic [31:0]        headData,
    output logic               full,
    output logic               empty,
    input  logic [IDX_MAX-1:0] matchIdx,
    output logic               matchHit,
    output logic [31:0]        matchData
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [PTR_W:0]     count;
    logic               doPush;
    logic               doPop;

    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    assign headIdx  = entries[headPtr].idx;
    assign headData = entries[headPtr].data;

    // Pointer and occupancy bookkeeping; reset discards every pending store.
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doPush) tailPtr <= tailPtr + 1'b1;
            if (doPop)  headPtr <= headPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between tail and head so no reset needed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            entries[tailPtr].idx  <= pushIdx;
            entries[tailPtr].data <= pushData;
        end
    end

    // Walk from oldest to youngest so the last hit seen is the youngest matching store.
    always_comb begin
        logic [PTR_W-1:0] pos;
        matchHit  = 1'b0;
        matchData = '0;
        pos       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = headPtr + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (entries[pos].idx == matchIdx)) begin
                matchHit  = 1'b1;
                matchData = entries[pos].data;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: drives the data memory port, posts stores into a
// buffer that drains in bubble cycles, and forwards buffered stores to loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF,
    parameter int IDX_BITS = IDX_BITS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        sb_empty,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] MemReadData
);

    logic               reqAccepted;
    logic               aligned;
    logic               singleOp;
    logic               doLoad;
    logic               doStore;
    logic               doMisalign;
    logic               doDrain;
    logic [IDX_MAX-1:0] reqIdx;
    logic [IDX_MAX-1:0] headIdx;
    logic [31:0]        headData;
    logic               sbFull;
    logic               sbEmpty;
    logic               fwdHit;
    logic [31:0]        fwdData;
    logic [31:0]        loadResult;
    logic               ldValid_p1;
    logic [31:0]        ldData_p1;
    logic               misalign_p1;

    // Request decode: a load+store collision is accepted but does nothing.
    assign reqAccepted = req_valid && req_ready;
    assign aligned     = (req_addr[1:0] == 2'b00);
    assign singleOp    = req_load ^ req_store;
    assign doLoad      = !reset && reqAccepted && singleOp && req_load  && aligned;
    assign doStore     = !reset && reqAccepted && singleOp && req_store && aligned;
    assign doMisalign  = !reset && reqAccepted && singleOp && !aligned;
    assign doDrain     = !reset && !reqAccepted && !sbEmpty;
    assign reqIdx      = wordIdx(req_addr, IDX_BITS);

    assign req_ready = !sbFull;
    assign sb_empty  = sbEmpty;

    store_buffer_fifo #(
        .DEPTH (SB_DEPTH)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .push      (doStore),
        .pushIdx   (reqIdx),
        .pushData  (req_wdata),
        .pop       (doDrain),
        .headIdx   (headIdx),
        .headData  (headData),
        .full      (sbFull),
        .empty     (sbEmpty),
        .matchIdx  (reqIdx),
        .matchHit  (fwdHit),
        .matchData (fwdData)
    );

    assign loadResult = fwdHit ? fwdData : MemReadData;

    // Memory port mux: a load owns the port on accepted cycles, drains use bubbles, otherwise idle zeros.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        if (doLoad) begin
            MemRead = 1'b1;
            Address = {reqIdx, 2'b00};
        end else if (doDrain) begin
            MemWrite  = 1'b1;
            Address   = {headIdx, 2'b00};
            WriteData = headData;
        end
    end

    // MEM -> WB boundary: load result and misalignment pulse registered one cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            ldValid_p1  <= 1'b0;
            ldData_p1   <= '0;
            misalign_p1 <= 1'b0;
        end else begin
            ldValid_p1  <= doLoad;
            misalign_p1 <= doMisalign;
            if (doLoad) ldData_p1 <= loadResult;
        end
    end

    assign ld_valid = ldValid_p1;
    assign ld_data  = ldData_p1;
    assign misalign = misalign_p1;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store unit of the MIPS pipeline; it is the initiator that drives the data memory port (MemRead, MemWrite, Address, WriteData) from LW/SW requests. Stores are posted into a small in-order store buffer and written to memory only in bubble cycles. Loads read memory combinationally and are forwarded from the youngest matching buffered store. The load result is registered toward MEM/WB.

## Interface
- SB_DEPTH, 4, store-buffer entries (power of 2, ≥2)
- IDX_BITS, 8, word-index bits compared and driven (256-word memory ⇒ Address[9:2])

- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM-stage instruction is a memory op
- req_load  in  1  LW
- req_store  in  1  SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_ready  out  1  request accepted this cycle; 0 ⇒ pipeline stalls
- ld_valid  out  1  registered; load data valid
- ld_data  out  32  registered load result
- misalign  out  1  registered one-cycle pulse: unaligned access dropped
- sb_empty  out  1  store buffer empty (used for drain/fence)
- MemRead  out  1  to data memory
- MemWrite  out  1  to data memory
- Address  out  32  to data memory, {zeros, idx, 2'b00}
- WriteData  out  32  to data memory
- MemReadData  in  32  combinational read data from memory

## Operation
- Request accepted ⇔ req_valid & req_ready; req_ready = !full.
- req_load & req_store both high: request accepted and ignored (no access, no pulse).
- Unaligned (req_addr[1:0]≠0) load or store: accepted, no memory access, no enqueue; misalign=1 next cycle, ld_valid=0.
- Aligned store: enqueue {idx=req_addr[IDX_BITS+1:2], data} at tail; no memory access that cycle.
- Aligned load: MemRead=1, Address=req_addr word-aligned. Result = data of youngest buffer entry with equal idx, else MemReadData. Registered into ld_data, ld_valid=1 next cycle.
- Drain: in any cycle with no accepted request (req_valid=0 or req_ready=0) and buffer non-empty: MemWrite=1, Address/WriteData from head; head popped at that edge.
- MemRead and MemWrite never both 1; both 0 while reset=1.
- Upper address bits beyond IDX_BITS+2 ignored (aliasing matches memory).
- Idle outputs: Address=0, WriteData=0.

## Timing
- Reset (sync): pointers/count cleared, ld_valid=0, ld_data=0, misalign=0, sb_empty=1 after the edge. Pending stores discarded, never written.
- Load latency 1 cycle (request edge → ld_valid). ld_valid is a one-cycle pulse per load.
- Store commit: earliest the first bubble cycle after enqueue; forwarding guarantees RAW correctness meanwhile.
- Full: req_ready=0; that cycle is a bubble, so head drains; req_ready=1 next cycle (one-cycle stall).
- Enqueue and drain never coincide (drain only on non-accepted cycles).
- Count wraps via SB_DEPTH-sized circular pointers; full = count==SB_DEPTH, empty = count==0.

## Structure
- Package lsu_pkg: SB_DEPTH/IDX_BITS defaults, sb_entry_t {idx, data}, word-index extraction helper.
- Sub-module store_buffer_fifo: circular FIFO with push/pop, full/empty, and youngest-match search port (idx in → hit, data out). Top holds request decode, port muxing, load result register.

## Test plan
- Reset; SW 0x10←0xDEADBEEF; idle → next cycle MemWrite=1, Address=0x10, WriteData=0xDEADBEEF; sb_empty=1 after.
- SW 0x20←0x11111111 then LW 0x20 back-to-back → ld_data=0x11111111, ld_valid=1 one cycle after LW, no MemWrite during load.
- SW 0x30←0xA, SW 0x30←0xB, LW 0x30 (memory holds 0) → ld_data=0xB; later two drains write 0xA then 0xB in order.
- Five back-to-back SW with SB_DEPTH=4 → req_ready=0 on fifth for exactly one cycle, one drain that cycle, fifth accepted next.
- LW 0x06 → misalign=1 next cycle, ld_valid=0, MemRead never asserted.
- Three stores pending, assert reset one cycle → sb_empty=1, ld_valid=0, no MemWrite during or after reset.
